// File: rtl/memshare_sched_ctrl_if.sv
// Request and register-file write handshakes between the host side and the memShare sequencer.
// The master drives valid and payload. The slave returns ready.
interface memshare_sched_ctrl_if #(
    parameter int SHARE_GROUP_SIZE        = 5,
    parameter int RQST_ADDR_BITWIDTH      = 2,
    parameter int L1PA_REGFILE_ADDR_WIDTH = 6,
    parameter int L1PA_REGFILE_PAGE_WIDTH = 7
);
    logic                                         rqst_valid_i;
    logic                                         rqst_ready_o;
    logic [RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:0] rqst_addr_i;
    logic                                         cfg_valid_i;
    logic                                         cfg_ready_o;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0]           cfg_waddr_i;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0]           cfg_wdata_i;

    modport master (
        output rqst_valid_i, rqst_addr_i, cfg_valid_i, cfg_waddr_i, cfg_wdata_i,
        input  rqst_ready_o, cfg_ready_o
    );

    modport slave (
        input  rqst_valid_i, rqst_addr_i, cfg_valid_i, cfg_waddr_i, cfg_wdata_i,
        output rqst_ready_o, cfg_ready_o
    );
endinterface

// File: rtl/memshare_sched_ctrl.sv
// Sequencer for SCU.memShare(): holds the request, waits PIPE_LAT cycles, then streams L1PA shifts registered one cycle later.
// Requests and config writes are accepted only in IDLE, and config wins a tie.
module memshare_sched_ctrl #(
    parameter int SHARE_GROUP_SIZE        = 5,
    parameter int RQST_ADDR_BITWIDTH      = 2,
    parameter int L1PA_REGFILE_ADDR_WIDTH = 6,
    parameter int L1PA_REGFILE_PAGE_WIDTH = 7,
    parameter int PIPE_LAT                = 3,
    parameter int MAX_PATTERNS            = 8
) (
    input  logic                                           sys_clk,
    input  logic                                           rst,
    memshare_sched_ctrl_if.slave                           req_if,
    output logic [RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:0] rqst_addr_o,
    output logic                                           scu_memShare_busy_o,
    output logic [L1PA_REGFILE_ADDR_WIDTH-1:0]             regType0_waddr_o,
    output logic [L1PA_REGFILE_PAGE_WIDTH-1:0]             regType0_wdata_o,
    output logic                                           regType0_we_o,
    input  logic [$clog2(SHARE_GROUP_SIZE)-1:0]            l1pa_shift_i,
    input  logic                                           isGtr_i,
    output logic                                           shift_valid_o,
    output logic [$clog2(SHARE_GROUP_SIZE)-1:0]            shift_o,
    output logic                                           shift_last_o,
    output logic                                           done_o,
    output logic                                           err_overrun_o
);
    localparam int ADDR_W  = RQST_ADDR_BITWIDTH * SHARE_GROUP_SIZE;
    localparam int SHIFT_W = $clog2(SHARE_GROUP_SIZE);
    localparam int LAT_W   = $clog2(PIPE_LAT + 1);
    localparam int PAT_W   = $clog2(MAX_PATTERNS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t                               state_q;
    logic [LAT_W-1:0]                     lat_cnt_q;
    logic [PAT_W-1:0]                     pat_cnt_q;
    logic [ADDR_W-1:0]                    rqst_addr_q;
    logic                                 busy_q;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0]   waddr_q;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0]   wdata_q;
    logic                                 we_q;
    logic                                 shift_valid_q;
    logic [SHIFT_W-1:0]                   shift_q;
    logic                                 shift_last_q;
    logic                                 done_q;
    logic                                 err_q;

    // Only the two ready signals are combinational; everything else leaves a flop.
    assign req_if.cfg_ready_o  = (state_q == S_IDLE);
    assign req_if.rqst_ready_o = (state_q == S_IDLE) && !req_if.cfg_valid_i;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lat_cnt_q     <= '0;
            pat_cnt_q     <= '0;
            rqst_addr_q   <= '0;
            busy_q        <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            shift_valid_q <= 1'b0;
            shift_q       <= '0;
            shift_last_q  <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            we_q          <= 1'b0;
            shift_valid_q <= 1'b0;
            shift_last_q  <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_if.cfg_valid_i) begin
                        we_q    <= 1'b1;
                        waddr_q <= req_if.cfg_waddr_i;
                        wdata_q <= req_if.cfg_wdata_i;
                    end else if (req_if.rqst_valid_i) begin
                        rqst_addr_q <= req_if.rqst_addr_i;
                        busy_q      <= 1'b1;
                        lat_cnt_q   <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(PIPE_LAT - 1)) begin
                        pat_cnt_q <= '0;
                        state_q   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    shift_valid_q <= 1'b1;
                    shift_q       <= l1pa_shift_i;
                    pat_cnt_q     <= pat_cnt_q + PAT_W'(1);
                    // A full table without the last-pattern flag is forced to end and flagged.
                    if (isGtr_i || (pat_cnt_q == PAT_W'(MAX_PATTERNS - 1))) begin
                        shift_last_q <= 1'b1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                        if (!isGtr_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rqst_addr_o         = rqst_addr_q;
    assign scu_memShare_busy_o = busy_q;
    assign regType0_waddr_o    = waddr_q;
    assign regType0_wdata_o    = wdata_q;
    assign regType0_we_o       = we_q;
    assign shift_valid_o       = shift_valid_q;
    assign shift_o             = shift_q;
    assign shift_last_o        = shift_last_q;
    assign done_o              = done_q;
    assign err_overrun_o       = err_q;
endmodule

// File: tb/tb_memshare_sched_ctrl.sv
// Randomized and directed bench for memshare_sched_ctrl against a cycle-arithmetic reference model.
module tb_memshare_sched_ctrl;
    localparam int SGS      = 5;
    localparam int RAB      = 2;
    localparam int AW       = 6;
    localparam int PW       = 7;
    localparam int PIPE_LAT = 3;
    localparam int MAXP     = 8;
    localparam int RA_W     = RAB * SGS;
    localparam int SH_W     = $clog2(SGS);

    logic sys_clk = 1'b0;
    logic rst;
    logic [SH_W-1:0] l1pa_shift;
    logic isGtr;

    logic [RA_W-1:0] rqst_addr_o;
    logic            busy_o;
    logic [AW-1:0]   waddr_o;
    logic [PW-1:0]   wdata_o;
    logic            we_o;
    logic            shift_valid_o;
    logic [SH_W-1:0] shift_o;
    logic            shift_last_o;
    logic            done_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    memshare_sched_ctrl_if #(
        .SHARE_GROUP_SIZE(SGS), .RQST_ADDR_BITWIDTH(RAB),
        .L1PA_REGFILE_ADDR_WIDTH(AW), .L1PA_REGFILE_PAGE_WIDTH(PW)
    ) rif ();

    memshare_sched_ctrl #(
        .SHARE_GROUP_SIZE(SGS), .RQST_ADDR_BITWIDTH(RAB),
        .L1PA_REGFILE_ADDR_WIDTH(AW), .L1PA_REGFILE_PAGE_WIDTH(PW),
        .PIPE_LAT(PIPE_LAT), .MAX_PATTERNS(MAXP)
    ) dut (
        .sys_clk             (sys_clk),
        .rst                 (rst),
        .req_if              (rif.slave),
        .rqst_addr_o         (rqst_addr_o),
        .scu_memShare_busy_o (busy_o),
        .regType0_waddr_o    (waddr_o),
        .regType0_wdata_o    (wdata_o),
        .regType0_we_o       (we_o),
        .l1pa_shift_i        (l1pa_shift),
        .isGtr_i             (isGtr),
        .shift_valid_o       (shift_valid_o),
        .shift_o             (shift_o),
        .shift_last_o        (shift_last_o),
        .done_o              (done_o),
        .err_overrun_o       (err_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation accepted at edge t samples the pattern stream on
    // edges t+PIPE_LAT+1 onward until the last flag or MAXP samples, one result per edge.
    bit              model_on = 1'b0;
    bit              m_active = 1'b0;
    int              cyc = 0;
    int              acc_edge = 0;
    int              nsamp = 0;
    logic [RA_W-1:0] e_addr;
    logic            e_busy, e_we, e_valid, e_last, e_done, e_err;
    logic [AW-1:0]   e_waddr;
    logic [PW-1:0]   e_wdata;
    logic [SH_W-1:0] e_shift;

    always @(posedge sys_clk) begin
        cyc++;
        if (rst) begin
            model_on = 1'b1;
            m_active = 1'b0;
            e_addr = '0; e_busy = 0; e_we = 0; e_valid = 0; e_last = 0; e_done = 0; e_err = 0;
            e_waddr = '0; e_wdata = '0; e_shift = '0;
        end else if (model_on) begin
            e_we = 0; e_valid = 0; e_last = 0; e_done = 0;
            if (!m_active) begin
                if (rif.cfg_valid_i) begin
                    e_we = 1; e_waddr = rif.cfg_waddr_i; e_wdata = rif.cfg_wdata_i;
                end else if (rif.rqst_valid_i) begin
                    m_active = 1'b1; acc_edge = cyc; nsamp = 0;
                    e_addr = rif.rqst_addr_i; e_busy = 1;
                end
            end else if (cyc > acc_edge + PIPE_LAT) begin
                nsamp++;
                e_valid = 1; e_shift = l1pa_shift;
                if (isGtr || nsamp == MAXP) begin
                    e_last = 1; e_done = 1; e_busy = 0; m_active = 1'b0;
                    if (!isGtr) e_err = 1;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (model_on) begin
            chk("cfg_ready", {31'd0, rif.cfg_ready_o}, {31'd0, !m_active});
            chk("rqst_ready", {31'd0, rif.rqst_ready_o}, {31'd0, !m_active && !rif.cfg_valid_i});
            chk("rqst_addr", 32'(rqst_addr_o), 32'(e_addr));
            chk("busy", {31'd0, busy_o}, {31'd0, e_busy});
            chk("we", {31'd0, we_o}, {31'd0, e_we});
            if (e_we) begin
                chk("waddr", 32'(waddr_o), 32'(e_waddr));
                chk("wdata", 32'(wdata_o), 32'(e_wdata));
            end
            chk("shift_valid", {31'd0, shift_valid_o}, {31'd0, e_valid});
            if (e_valid) chk("shift", 32'(shift_o), 32'(e_shift));
            chk("shift_last", {31'd0, shift_last_o}, {31'd0, e_last});
            chk("done", {31'd0, done_o}, {31'd0, e_done});
            chk("err_overrun", {31'd0, err_o}, {31'd0, e_err});
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Leaves the caller at the negedge of the done cycle when found.
    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (done_o) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        logic [7:0] busy_tbl, valid_tbl, done_tbl;
        int  nval, nlast, ndone;
        bit  got;
        busy_tbl  = 8'b0011_1111;
        valid_tbl = 8'b0111_0000;
        done_tbl  = 8'b0100_0000;

        rst = 1'b1;
        rif.rqst_valid_i = 1'b0; rif.rqst_addr_i = '0;
        rif.cfg_valid_i = 1'b0; rif.cfg_waddr_i = '0; rif.cfg_wdata_i = '0;
        l1pa_shift = '0; isGtr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_addr", 32'(rqst_addr_o), 32'd0);
        chk("rst_cfg_ready", {31'd0, rif.cfg_ready_o}, 32'd1);
        chk("rst_rqst_ready", {31'd0, rif.rqst_ready_o}, 32'd1);
        chk("rst_err", {31'd0, err_o}, 32'd0);

        // Three-pattern sequence, last flag on the third STREAM sample.
        step();
        rif.rqst_valid_i = 1'b1; rif.rqst_addr_i = 10'h2D5;
        step();
        rif.rqst_valid_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            l1pa_shift = SH_W'(i - 3);
            isGtr = (i == 6);
            @(negedge sys_clk);
            chk("seq3_busy", {31'd0, busy_o}, {31'd0, busy_tbl[i-1]});
            chk("seq3_valid", {31'd0, shift_valid_o}, {31'd0, valid_tbl[i-1]});
            chk("seq3_done", {31'd0, done_o}, {31'd0, done_tbl[i-1]});
            if (i == 7) begin
                chk("seq3_last_shift", 32'(shift_o), 32'd3);
                chk("seq3_last", {31'd0, shift_last_o}, 32'd1);
                chk("seq3_addr", 32'(rqst_addr_o), 32'h2D5);
            end
            step();
        end

        // Single-pattern sequence.
        isGtr = 1'b1;
        rif.rqst_valid_i = 1'b1; rif.rqst_addr_i = 10'h0F3;
        step();
        rif.rqst_valid_i = 1'b0;
        nval = 0; ndone = 0;
        for (int i = 0; i < 12; i++) begin
            l1pa_shift = SH_W'($urandom);
            @(negedge sys_clk);
            if (shift_valid_o) nval++;
            if (done_o) begin
                ndone++;
                chk("single_last", {31'd0, shift_last_o}, 32'd1);
            end
            step();
        end
        chk("single_nvalid", 32'(nval), 32'd1);
        chk("single_ndone", 32'(ndone), 32'd1);

        // Overrun: last flag never arrives.
        isGtr = 1'b0;
        rif.rqst_valid_i = 1'b1;
        step();
        rif.rqst_valid_i = 1'b0;
        nval = 0; nlast = 0;
        for (int i = 0; i < 20; i++) begin
            l1pa_shift = SH_W'($urandom);
            @(negedge sys_clk);
            if (shift_valid_o) nval++;
            if (shift_last_o) nlast++;
            step();
        end
        chk("ovr_nvalid", 32'(nval), 32'd8);
        chk("ovr_nlast", 32'(nlast), 32'd1);
        chk("ovr_err", {31'd0, err_o}, 32'd1);
        repeat (5) step();
        chk("ovr_err_sticky", {31'd0, err_o}, 32'd1);

        // Config and request together; config wins, then config stalls while busy.
        isGtr = 1'b1;
        rif.cfg_valid_i = 1'b1; rif.cfg_waddr_i = 6'h3F; rif.cfg_wdata_i = 7'h55;
        rif.rqst_valid_i = 1'b1; rif.rqst_addr_i = 10'h13A;
        @(negedge sys_clk);
        chk("tie_rqst_ready", {31'd0, rif.rqst_ready_o}, 32'd0);
        chk("tie_cfg_ready", {31'd0, rif.cfg_ready_o}, 32'd1);
        step();
        rif.cfg_valid_i = 1'b0;
        @(negedge sys_clk);
        chk("tie_we", {31'd0, we_o}, 32'd1);
        chk("tie_waddr", 32'(waddr_o), 32'h3F);
        chk("tie_wdata", 32'(wdata_o), 32'h55);
        chk("tie_rqst_ready_next", {31'd0, rif.rqst_ready_o}, 32'd1);
        step();
        rif.rqst_valid_i = 1'b0;
        rif.cfg_valid_i = 1'b1; rif.cfg_waddr_i = 6'h0A; rif.cfg_wdata_i = 7'h2A;
        @(negedge sys_clk);
        chk("busy_cfg_ready", {31'd0, rif.cfg_ready_o}, 32'd0);
        chk("tie_busy", {31'd0, busy_o}, 32'd1);
        step();
        wait_done(got);
        chk("cfg_wait_done", {31'd0, got}, 32'd1);
        chk("done_cfg_ready", {31'd0, rif.cfg_ready_o}, 32'd1);
        step();
        rif.cfg_valid_i = 1'b0;
        @(negedge sys_clk);
        chk("late_we", {31'd0, we_o}, 32'd1);
        chk("late_waddr", 32'(waddr_o), 32'h0A);

        // Back-to-back requests: second accepted in the done cycle.
        step();
        rif.rqst_valid_i = 1'b1; rif.rqst_addr_i = 10'h311;
        step();
        rif.rqst_addr_i = 10'h0C6;
        wait_done(got);
        chk("b2b_done", {31'd0, got}, 32'd1);
        chk("b2b_rqst_ready", {31'd0, rif.rqst_ready_o}, 32'd1);
        step();
        rif.rqst_valid_i = 1'b0;
        @(negedge sys_clk);
        chk("b2b_busy", {31'd0, busy_o}, 32'd1);
        chk("b2b_addr", 32'(rqst_addr_o), 32'h0C6);
        step();
        wait_done(got);
        chk("b2b_done2", {31'd0, got}, 32'd1);

        // Reset during WAIT, then during STREAM, then a normal run.
        step();
        isGtr = 1'b0;
        rif.rqst_valid_i = 1'b1;
        step();
        rif.rqst_valid_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge sys_clk);
        chk("rstw_busy", {31'd0, busy_o}, 32'd0);
        chk("rstw_done", {31'd0, done_o}, 32'd0);
        chk("rstw_err", {31'd0, err_o}, 32'd0);
        step();
        rif.rqst_valid_i = 1'b1;
        step();
        rif.rqst_valid_i = 1'b0;
        repeat (PIPE_LAT + 2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge sys_clk);
        chk("rsts_busy", {31'd0, busy_o}, 32'd0);
        chk("rsts_valid", {31'd0, shift_valid_o}, 32'd0);
        chk("rsts_done", {31'd0, done_o}, 32'd0);
        step();
        isGtr = 1'b1;
        rif.rqst_valid_i = 1'b1; rif.rqst_addr_i = 10'h2AA;
        step();
        rif.rqst_valid_i = 1'b0;
        wait_done(got);
        chk("post_rst_done", {31'd0, got}, 32'd1);
        chk("post_rst_last", {31'd0, shift_last_o}, 32'd1);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 299) == 0);
            rif.rqst_valid_i = ($urandom_range(0, 3) == 0);
            rif.rqst_addr_i  = RA_W'($urandom);
            rif.cfg_valid_i  = ($urandom_range(0, 5) == 0);
            rif.cfg_waddr_i  = AW'($urandom);
            rif.cfg_wdata_i  = PW'($urandom);
            l1pa_shift       = SH_W'($urandom);
            isGtr            = ($urandom_range(0, 4) == 0);
            step();
        end
        rst = 1'b0; rif.rqst_valid_i = 1'b0; rif.cfg_valid_i = 1'b0; isGtr = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
